mtn_sync_sched: RTL and testbench
=================================

# mtn_sync_sched

Multi-axis segment scheduler sitting between the host segment FIFO and the per-axis pulse controllers. Pops one segment record (signed count and period per axis), presents it to every axis, waits until all axes have latched it and report ready, then issues a single-cycle synchronous start (`oi`) so all axes begin the segment on the same clock. Supplies the `empty`, `N`, `T` and `oi` inputs of the axis controllers and consumes their `oi_req` and `run` outputs.

## Interface
- `AXES`, 4: number of axis controllers driven
- `TIMEOUT`, 32'd50_000_000: max cycles in DIST before timeout error (used only with `MTN_SYNC_SCHED_TIMEOUT_EN`)
- `clk`  in  1  system clock, all logic on rising edge
- `aclr_n`  in  1  reset, asynchronous, active-low
- `abort`  in  1  synchronous abort, highest priority after reset
- `seg_valid`  in  1  FIFO not empty
- `seg_ready`  out  1  one-cycle pop strobe to FIFO
- `seg_N`  in  AXES*32  signed step counts, axis k at [32k+31:32k]
- `seg_T`  in  AXES*32  unsigned periods, same packing
- `axis_N`  out  AXES*32  registered counts to axes
- `axis_T`  out  AXES*32  registered periods to axes
- `axis_empty`  out  1  shared; 0 = segment offered to axes
- `axis_oi_req`  in  AXES  per-axis ready-to-start
- `axis_run`  in  AXES  per-axis running
- `oi`  out  1  synchronous start pulse, shared by all axes
- `busy`  out  1  state != IDLE or any `axis_run`
- `seg_cnt`  out  32  segments started, wraps 2^32-1 -> 0
- `err_timeout`  out  1  sticky timeout flag

## Operation
- States: IDLE, DIST, SYNC.
- IDLE: `axis_empty`=1, `oi`=0. If `seg_valid`: `seg_ready`=1 this cycle (combinational, `state==IDLE && seg_valid`), capture `seg_N`/`seg_T` into `axis_N`/`axis_T`, -> DIST.
- DIST: `axis_empty`=0. When `&axis_oi_req` -> SYNC. Axes latch the record on their own; a stale `oi_req` is impossible since axes only assert it after latching.
- SYNC: `axis_empty`=1, `oi`=1 (one cycle), `seg_cnt`+1, -> IDLE.
- Next segment may be offered while axes still run; axes hold in their ready state until the next `oi`, so prefetch is safe.
- Axes with N=0,T=0 (M command) and N=0,T>0 (pause) participate identically; no special casing.
- `abort`: state -> IDLE, `oi`=0, `axis_empty`=1, `err_timeout` cleared; `axis_N`/`axis_T` hold; `seg_cnt` holds; no pop that cycle.
- Reset: state IDLE, `axis_N`=0, `axis_T`='1, `axis_empty`=1, `oi`=0, `seg_ready`=0, `seg_cnt`=0, `err_timeout`=0, `busy`=0 when `axis_run`=0.

## Timing
- Pop-to-offer: `axis_empty` falls 1 cycle after `seg_ready` strobe.
- All `oi_req` high in cycle c -> `oi` high in cycle c+1 exactly, low in c+2.
- Minimum segment period through scheduler: 3 cycles (IDLE, DIST, SYNC) plus axis latch latency.
- `abort` and `&axis_oi_req` in same cycle: abort wins, no `oi`.
- `abort` and `seg_valid` in IDLE same cycle: no pop.

## Configuration
- `MTN_SYNC_SCHED_TIMEOUT_EN` defined: 32-bit counter cleared on DIST entry, increments each DIST cycle; reaching `TIMEOUT` sets `err_timeout`, state -> IDLE, `axis_empty`=1, no `oi`, segment dropped (already popped). Host must `abort` axes.
- Undefined: no counter, DIST waits indefinitely, `err_timeout` tied 0.

## Structure
- Package `mtn_pkg`: state enum `mtn_state_t` {IDLE, DIST, SYNC}, `MTN_W`=32 data width, default `AXES`.
- One sub-module natural: `mtn_tmo_cnt` (timeout counter, clear/enable/expired), instantiated only under the macro.

## Test plan
- Reset with `aclr_n`=0 mid-DIST -> all outputs at reset values within same cycle, `axis_empty`=1.
- One segment N={100,-50,0,0}, T={10,20,0,5}, all axes raise `oi_req` on different cycles (last at c) -> single `oi` pulse at c+1, `seg_cnt`=1, one `seg_ready` strobe.
- Two back-to-back segments with `seg_valid` held -> second `seg_ready` 1 cycle after first `oi`, second `oi` only after all axes re-assert `oi_req`.
- `abort` in same cycle as `&axis_oi_req` -> no `oi`, state IDLE, `seg_cnt` unchanged.
- With macro, TIMEOUT=16, axis 2 never raises `oi_req` -> `err_timeout`=1 after 16 DIST cycles, no `oi`; `abort` clears it.
- `seg_cnt` preset path: 2^32 segments via forced value 32'hFFFF_FFFF -> next `oi` wraps to 0.

Source files
------------

// File: rtl/mtn_pkg.sv
// Shared types and constants for the multi-axis segment scheduler.
package mtn_pkg;

  // Data width of one per-axis count or period field.
  localparam int MTN_W = 32;

  // Default number of axis controllers driven by the scheduler.
  localparam int AXES_DEF = 4;

  // Scheduler states: wait for a segment, offer it to the axes, fire the start.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIST = 2'd1,
    SYNC = 2'd2
  } mtn_state_t;

endpackage

// File: rtl/mtn_tmo_cnt.sv
// DIST-phase timeout counter: cleared while not distributing, counts each
// distributing cycle and flags the cycle in which the limit is reached.
module mtn_tmo_cnt #(
  parameter logic [31:0] LIMIT = 32'd50_000_000
) (
  input  logic clk,
  input  logic aclr_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Next count: clear has priority, otherwise step while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of earlier DIST cycles, so this is the LIMIT-th one.
  assign expired_o = en_i && (cnt_q == (LIMIT - 32'd1));

endmodule

// File: rtl/mtn_sync_sched.sv
// Multi-axis segment scheduler: pops one segment record from the host FIFO,
// offers it to every axis, waits for all axes to report ready, then issues
// one synchronous start pulse (oi) shared by all axes.
// Optional feature macro: MTN_SYNC_SCHED_TIMEOUT_EN adds a DIST timeout that
// drops the segment and raises the sticky err_timeout flag.
//
// Handshakes: seg_ready is a single-cycle pop strobe, high exactly when the
// scheduler is IDLE, seg_valid is high, abort is low and reset is released;
// the record on seg_N/seg_T is consumed on that rising edge. Towards the axes,
// axis_empty=0 means "record on axis_N/axis_T is valid"; each axis answers
// with axis_oi_req once it has latched it, and oi starts all of them at once.
module mtn_sync_sched
  import mtn_pkg::*;
#(
  parameter int          AXES    = AXES_DEF,
  parameter logic [31:0] TIMEOUT = 32'd50_000_000
) (
  input  logic                    clk,
  input  logic                    aclr_n,
  input  logic                    abort,
  input  logic                    seg_valid,
  output logic                    seg_ready,
  input  logic [AXES*MTN_W-1:0]   seg_N,
  input  logic [AXES*MTN_W-1:0]   seg_T,
  output logic [AXES*MTN_W-1:0]   axis_N,
  output logic [AXES*MTN_W-1:0]   axis_T,
  output logic                    axis_empty,
  input  logic [AXES-1:0]         axis_oi_req,
  input  logic [AXES-1:0]         axis_run,
  output logic                    oi,
  output logic                    busy,
  output logic [MTN_W-1:0]        seg_cnt,
  output logic                    err_timeout,
  output mtn_state_t              dbg_state
);

  mtn_state_t              state_q;
  logic [AXES*MTN_W-1:0]   axis_n_q;
  logic [AXES*MTN_W-1:0]   axis_t_q;
  logic                    empty_q;
  logic                    oi_q;
  logic [MTN_W-1:0]        seg_cnt_q;
  logic                    err_q;
  logic                    all_ready;
  logic                    tmo_expired;

  assign all_ready = &axis_oi_req;

`ifdef MTN_SYNC_SCHED_TIMEOUT_EN
  // Timeout counter only exists when the feature is built in.
  mtn_tmo_cnt #(
    .LIMIT (TIMEOUT)
  ) u_tmo_cnt (
    .clk       (clk),
    .aclr_n    (aclr_n),
    .clr_i     (state_q != DIST),
    .en_i      (state_q == DIST),
    .expired_o (tmo_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo_expired    = 1'b0;
`endif

  // Scheduler FSM with registered axis-facing outputs; abort overrides all.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q   <= IDLE;
      axis_n_q  <= '0;
      axis_t_q  <= '1;
      empty_q   <= 1'b1;
      oi_q      <= 1'b0;
      seg_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      oi_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        empty_q <= 1'b1;
        err_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (seg_valid) begin
              axis_n_q <= seg_N;
              axis_t_q <= seg_T;
              empty_q  <= 1'b0;
              state_q  <= DIST;
            end
          end
          DIST: begin
            if (all_ready) begin
              empty_q   <= 1'b1;
              oi_q      <= 1'b1;
              seg_cnt_q <= seg_cnt_q + 32'd1;
              state_q   <= SYNC;
            end else if (tmo_expired) begin
              empty_q <= 1'b1;
              err_q   <= 1'b1;
              state_q <= IDLE;
            end
          end
          SYNC: begin
            state_q <= IDLE;
          end
          default: begin
            empty_q <= 1'b1;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  // Pop strobe is combinational so the FIFO advances on the capture edge.
  assign seg_ready   = aclr_n && !abort && seg_valid && (state_q == IDLE);

  assign axis_N      = axis_n_q;
  assign axis_T      = axis_t_q;
  assign axis_empty  = empty_q;
  assign oi          = oi_q;
  assign seg_cnt     = seg_cnt_q;
  assign busy        = (state_q != IDLE) || (|axis_run);
  assign dbg_state   = state_q;

`ifdef MTN_SYNC_SCHED_TIMEOUT_EN
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_mtn_sync_sched.sv
// Self-checking bench for mtn_sync_sched: table of segments with per-axis
// ready delays, plus hand-written sequences for back-to-back, abort, reset,
// counter wrap and (when built in) timeout.
module tb_mtn_sync_sched;
  import mtn_pkg::*;

  localparam int AXES = 4;
  localparam int W    = AXES * MTN_W;
  localparam int NVEC = 4;

  logic            clk = 1'b0;
  logic            aclr_n;
  logic            abort;
  logic            seg_valid;
  logic            seg_ready;
  logic [W-1:0]    seg_N;
  logic [W-1:0]    seg_T;
  logic [W-1:0]    axis_N;
  logic [W-1:0]    axis_T;
  logic            axis_empty;
  logic [AXES-1:0] axis_oi_req;
  logic [AXES-1:0] axis_run;
  logic            oi;
  logic            busy;
  logic [31:0]     seg_cnt;
  logic            err_timeout;
  mtn_state_t      dbg_state;

  // Clock and DUT.
  always #5 clk = ~clk;

  mtn_sync_sched #(
    .AXES    (AXES),
    .TIMEOUT (32'd16)
  ) dut (
    .clk         (clk),
    .aclr_n      (aclr_n),
    .abort       (abort),
    .seg_valid   (seg_valid),
    .seg_ready   (seg_ready),
    .seg_N       (seg_N),
    .seg_T       (seg_T),
    .axis_N      (axis_N),
    .axis_T      (axis_T),
    .axis_empty  (axis_empty),
    .axis_oi_req (axis_oi_req),
    .axis_run    (axis_run),
    .oi          (oi),
    .busy        (busy),
    .seg_cnt     (seg_cnt),
    .err_timeout (err_timeout),
    .dbg_state   (dbg_state)
  );

  // Scoreboard state.
  logic [2*W-1:0] exp_q[$];
  logic [31:0]    exp_cnt;
  int             checks;
  int             errors;
  int             oi_seen;
  int             pops_seen;

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] t;
    int           dly[AXES];
    int           exp_lat;
  } vec_t;

  vec_t vecs[NVEC];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: observe handshakes at the falling edge, then step past the
  // rising edge so the caller sees registered results.
  task automatic tick();
    logic [2*W-1:0] rec;
    @(negedge clk);
    if (seg_ready) begin
      exp_q.push_back({seg_N, seg_T});
      pops_seen++;
    end
    if (oi) begin
      oi_seen++;
      exp_cnt = exp_cnt + 32'd1;
      if (exp_q.size() == 0) begin
        chk("oi_without_segment", 256'd1, 256'd0);
      end else begin
        rec = exp_q.pop_front();
        chk("oi_axis_N", axis_N, rec[2*W-1:W]);
        chk("oi_axis_T", axis_T, rec[W-1:0]);
      end
      chk("oi_seg_cnt", seg_cnt, exp_cnt);
      chk("oi_axis_empty", axis_empty, 1'b1);
    end
    @(posedge clk);
    #1;
  endtask

  // Offer one segment and let the pop edge pass; leaves the DUT in DIST.
  task automatic pop_seg(input logic [W-1:0] n, input logic [W-1:0] t);
    seg_valid = 1'b1;
    seg_N     = n;
    seg_T     = t;
    #1;
    chk("pop_seg_ready", seg_ready, 1'b1);
    tick();
    seg_valid = 1'b0;
    #1;
    chk("offer_axis_empty", axis_empty, 1'b0);
    chk("offer_state", dbg_state, DIST);
  endtask

  function automatic logic [W-1:0] rand_rec();
    logic [W-1:0] r;
    for (int a = 0; a < AXES; a++) r[a*MTN_W +: MTN_W] = $urandom();
    return r;
  endfunction

  initial begin
    int lat;
    int oi_before;
    int pops_before;
    logic [31:0] cnt_hold;
    logic [W-1:0] n_hold;

    checks = 0; errors = 0; oi_seen = 0; pops_seen = 0; exp_cnt = '0;
    aclr_n = 1'b0; abort = 1'b0; seg_valid = 1'b1;
    seg_N = '0; seg_T = '0; axis_oi_req = '0; axis_run = '0;

    // Reset values (seg_valid high on purpose: no pop while in reset).
    #12;
    chk("rst_axis_N", axis_N, '0);
    chk("rst_axis_T", axis_T, {W{1'b1}});
    chk("rst_axis_empty", axis_empty, 1'b1);
    chk("rst_oi", oi, 1'b0);
    chk("rst_seg_ready", seg_ready, 1'b0);
    chk("rst_seg_cnt", seg_cnt, 32'd0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", dbg_state, IDLE);
    seg_valid = 1'b0;
    @(posedge clk); #1;
    aclr_n = 1'b1;
    tick();

    // Vector table: first entry is the reference segment, rest random.
    vecs[0].n = {32'sd0, 32'sd0, -32'sd50, 32'sd100};
    vecs[0].t = {32'd5, 32'd0, 32'd20, 32'd10};
    vecs[0].dly = '{1, 3, 2, 5};
    for (int v = 1; v < NVEC; v++) begin
      vecs[v].n = rand_rec();
      vecs[v].t = rand_rec();
      for (int a = 0; a < AXES; a++) vecs[v].dly[a] = $urandom_range(0, 6);
    end
    for (int v = 0; v < NVEC; v++) begin
      vecs[v].exp_lat = 0;
      for (int a = 0; a < AXES; a++)
        if (vecs[v].dly[a] > vecs[v].exp_lat) vecs[v].exp_lat = vecs[v].dly[a];
      vecs[v].exp_lat = vecs[v].exp_lat + 1;
    end

    for (int v = 0; v < NVEC; v++) begin
      oi_before   = oi_seen;
      pops_before = pops_seen;
      pop_seg(vecs[v].n, vecs[v].t);
      chk("vec_axis_N", axis_N, vecs[v].n);
      chk("vec_axis_T", axis_T, vecs[v].t);
      lat = 0;
      while (oi_seen == oi_before && !oi && lat < 20) begin
        for (int a = 0; a < AXES; a++) axis_oi_req[a] = (lat >= vecs[v].dly[a]);
        tick();
        lat++;
      end
      chk("vec_oi_latency", lat, vecs[v].exp_lat);
      chk("vec_oi_high", oi, 1'b1);
      chk("vec_state_sync", dbg_state, SYNC);
      axis_oi_req = '0;
      axis_run    = 4'b0101;
      tick();
      chk("vec_oi_low", oi, 1'b0);
      chk("vec_busy_running", busy, 1'b1);
      axis_run = '0;
      #1;
      chk("vec_busy_idle", busy, 1'b0);
      chk("vec_single_pop", pops_seen - pops_before, 1);
      chk("vec_single_oi", oi_seen - oi_before, 1);
    end

    // Back-to-back segments with seg_valid held high.
    oi_before = oi_seen;
    pop_seg(rand_rec(), rand_rec());
    seg_valid = 1'b1;
    seg_N = rand_rec();
    seg_T = rand_rec();
    #1;
    chk("b2b_no_pop_in_dist", seg_ready, 1'b0);
    axis_oi_req = '1;
    tick();
    chk("b2b_first_oi", oi, 1'b1);
    axis_oi_req = '0;
    axis_run    = '1;
    #1;
    chk("b2b_no_pop_in_sync", seg_ready, 1'b0);
    tick();
    chk("b2b_second_pop", seg_ready, 1'b1);
    tick();
    seg_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("b2b_wait_oi_low", oi, 1'b0);
    end
    axis_oi_req = 4'b0111;
    tick();
    chk("b2b_partial_oi_low", oi, 1'b0);
    axis_oi_req = '1;
    tick();
    chk("b2b_second_oi", oi, 1'b1);
    axis_oi_req = '0;
    axis_run    = '0;
    tick();
    chk("b2b_oi_count", oi_seen - oi_before, 2);

    // Abort in the same cycle as all axes ready: abort wins.
    cnt_hold = seg_cnt;
    pop_seg(rand_rec(), rand_rec());
    n_hold = exp_q[exp_q.size()-1][2*W-1:W];
    axis_oi_req = '1;
    abort = 1'b1;
    tick();
    void'(exp_q.pop_back());
    abort = 1'b0;
    axis_oi_req = '0;
    chk("abort_no_oi", oi, 1'b0);
    chk("abort_state", dbg_state, IDLE);
    chk("abort_axis_empty", axis_empty, 1'b1);
    chk("abort_seg_cnt_hold", seg_cnt, cnt_hold);
    chk("abort_axis_N_hold", axis_N, n_hold);
    tick();
    chk("abort_no_late_oi", oi, 1'b0);

    // Abort with seg_valid in IDLE: no pop.
    pops_before = pops_seen;
    seg_valid = 1'b1;
    seg_N = rand_rec();
    abort = 1'b1;
    #1;
    chk("abort_idle_no_ready", seg_ready, 1'b0);
    tick();
    abort = 1'b0;
    seg_valid = 1'b0;
    chk("abort_idle_state", dbg_state, IDLE);
    chk("abort_idle_N_hold", axis_N, n_hold);
    chk("abort_idle_no_pop", pops_seen - pops_before, 0);

`ifdef MTN_SYNC_SCHED_TIMEOUT_EN
    // Timeout: axis 2 never reports ready.
    oi_before = oi_seen;
    pop_seg(rand_rec(), rand_rec());
    axis_oi_req = 4'b1011;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("tmo_not_yet", err_timeout, 1'b0);
    end
    tick();
    void'(exp_q.pop_back());
    chk("tmo_err_set", err_timeout, 1'b1);
    chk("tmo_state_idle", dbg_state, IDLE);
    chk("tmo_axis_empty", axis_empty, 1'b1);
    chk("tmo_no_oi", oi_seen - oi_before, 0);
    axis_oi_req = '0;
    tick();
    chk("tmo_err_sticky", err_timeout, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("tmo_err_cleared", err_timeout, 1'b0);
`endif

    // Counter wrap from all-ones.
    force dut.seg_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.seg_cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    tick();
    chk("wrap_preset_hold", seg_cnt, 32'hFFFF_FFFF);
    pop_seg(rand_rec(), rand_rec());
    axis_oi_req = '1;
    tick();
    axis_oi_req = '0;
    chk("wrap_oi", oi, 1'b1);
    chk("wrap_seg_cnt", seg_cnt, 32'd0);
    tick();

    // Asynchronous reset in the middle of DIST.
    pop_seg(rand_rec(), rand_rec());
    tick();
    #2;
    aclr_n = 1'b0;
    #1;
    chk("midrst_axis_empty", axis_empty, 1'b1);
    chk("midrst_axis_N", axis_N, '0);
    chk("midrst_axis_T", axis_T, {W{1'b1}});
    chk("midrst_seg_cnt", seg_cnt, 32'd0);
    chk("midrst_state", dbg_state, IDLE);
    chk("midrst_oi", oi, 1'b0);
    exp_q.delete();
    exp_cnt = '0;
    @(posedge clk); #1;
    aclr_n = 1'b1;
    tick();
    chk("midrst_leftover_q", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global guard so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1);
  end

endmodule
